// File: rtl/spi_slave_frame_pkg.sv
// Shared types and defaults for the SPI frame slave.
// Defaults match the frame link driven by the team's SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } spi_slv_state_e;

    localparam int SPI_DEF_WIDTH   = 512;
    localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slave_frame_if.sv
// Serial line plus parallel register-bus side of the SPI frame slave.
// The slave modport is the view taken by spi_slave_frame.
interface spi_slave_frame_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DEF_WIDTH
);
    logic                  sclk;
    logic                  ss_n;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic [DATA_WIDTH-1:0] tx_data_i;
    logic [DATA_WIDTH-1:0] rx_data_o;
    logic                  rx_valid_o;
    logic                  busy_o;
    logic                  frame_err_o;
    logic                  overrun_o;

    modport slave (
        input  sclk, ss_n, mosi, tx_data_i,
        output miso, miso_oe, rx_data_o, rx_valid_o, busy_o, frame_err_o, overrun_o
    );

    modport master (
        output sclk, ss_n, mosi, tx_data_i,
        input  miso, miso_oe, rx_data_o, rx_valid_o, busy_o, frame_err_o, overrun_o
    );
endinterface

// File: rtl/spi_slave_frame_sync_edge.sv
// Multi-flop synchronizer for one asynchronous line, with optional
// single-cycle rise/fall pulses taken from the synchronized level.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = SPI_SYNC_STAGES,
    parameter logic RESET_VAL   = 1'b0,
    parameter bit   EDGE_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Flops reset to the idle line level so reset release creates no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic r_last;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_last <= RESET_VAL;
                end else begin
                    r_last <= o_sync;
                end
            end

            assign o_rise = o_sync & ~r_last;
            assign o_fall = ~o_sync & r_last;
        end else begin : g_noEdge
            assign o_rise = 1'b0;
            assign o_fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_slave_frame.sv
// SPI mode-0 frame slave: oversamples sclk in the clk domain, receives one
// DATA_WIDTH-bit MSB-first frame per select and shifts a response out on miso.
module spi_slave_frame
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DEF_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    spi_slave_frame_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    spi_slv_state_e r_state;
    spi_slv_state_e w_nextState;

    logic                  w_sclkRise;
    logic                  w_sclkFall;
    logic                  w_ssRise;
    logic                  w_ssFall;
    logic                  w_mosiSync;

    logic [DATA_WIDTH-1:0] r_txShift;
    logic [DATA_WIDTH-1:0] r_rxShift;
    logic [DATA_WIDTH-1:0] r_rxData;
    logic [CNT_W-1:0]      r_count;
    logic                  r_miso;
    logic                  r_rxValid;
    logic                  r_frameErr;
    logic                  r_overrun;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0),
        .EDGE_EN     (1'b1)
    ) u_sclkSync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.sclk),
        .o_sync  (),
        .o_rise  (w_sclkRise),
        .o_fall  (w_sclkFall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1),
        .EDGE_EN     (1'b1)
    ) u_ssSync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.ss_n),
        .o_sync  (),
        .o_rise  (w_ssRise),
        .o_fall  (w_ssFall)
    );

    // mosi shares the sclk pipeline depth, so it is aligned with w_sclkRise.
    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0),
        .EDGE_EN     (1'b0)
    ) u_mosiSync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.mosi),
        .o_sync  (w_mosiSync),
        .o_rise  (),
        .o_fall  ()
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ss_rise takes priority over any sclk edge seen in the same cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_ssFall) begin
                    w_nextState = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_ssRise) begin
                    w_nextState = IDLE;
                end else if (w_sclkRise && (r_count == CNT_W'(DATA_WIDTH - 1))) begin
                    w_nextState = FULL;
                end
            end
            FULL: begin
                if (w_ssRise) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txShift  <= '0;
            r_rxShift  <= '0;
            r_rxData   <= '0;
            r_count    <= '0;
            r_miso     <= 1'b0;
            r_rxValid  <= 1'b0;
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_rxValid  <= 1'b0;
            r_frameErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ssFall) begin
                        r_txShift <= bus.tx_data_i;
                        r_miso    <= bus.tx_data_i[DATA_WIDTH-1];
                        r_count   <= '0;
                        r_overrun <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (w_ssRise) begin
                        r_frameErr <= 1'b1;
                        r_miso     <= 1'b0;
                    end else if (w_sclkRise) begin
                        r_rxShift <= {r_rxShift[DATA_WIDTH-2:0], w_mosiSync};
                        r_count   <= r_count + CNT_W'(1);
                    end else if (w_sclkFall) begin
                        r_txShift <= {r_txShift[DATA_WIDTH-2:0], 1'b0};
                        r_miso    <= r_txShift[DATA_WIDTH-2];
                    end
                end
                FULL: begin
                    // Receive shift and count are frozen; extra clocks only flag overrun.
                    if (w_ssRise) begin
                        r_rxData  <= r_rxShift;
                        r_rxValid <= 1'b1;
                        r_miso    <= 1'b0;
                    end else if (w_sclkRise) begin
                        r_overrun <= 1'b1;
                    end else if (w_sclkFall) begin
                        r_miso <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.busy_o  = (r_state != IDLE);
        bus.miso_oe = (r_state != IDLE);
    end

    assign bus.miso        = r_miso;
    assign bus.rx_data_o   = r_rxData;
    assign bus.rx_valid_o  = r_rxValid;
    assign bus.frame_err_o = r_frameErr;
    assign bus.overrun_o   = r_overrun;

endmodule
